// File: rtl/ri_multicycle_ctrl.sv
// Multicycle IF/ID/EX/WB sequencer; RI_OVF_TRAP_EN turns add/sub/addi overflow into a trap to HALT.
// Latency 4 cycles per instruction; no backpressure, a stop pulse is latched and honoured after WB.
module ri_multicycle_ctrl #(
  parameter logic [5:0] HALT_OP = 6'b111111,
  parameter int         CNT_W   = 16
) (
  input  logic             clka,
  input  logic             rsta,
  input  logic             start,
  input  logic             stop,
  input  logic [31:0]      inst,
  input  logic             zfa,
  input  logic             ofa,
  output logic             pc_we,
  output logic             ir_we,
  output logic             rf_we,
  output logic [3:0]       alu_op,
  output logic             alu_src_imm,
  output logic             ext_sign,
  output logic             rf_dst_rt,
  output logic             busy,
  output logic             illegal,
  output logic             zf_q,
  output logic             of_q,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] inst_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

`ifdef RI_OVF_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  logic             stop_pend_q, stop_pend_d;
  logic             pc_we_q, pc_we_d;
  logic             ir_we_q, ir_we_d;
  logic             rf_we_q, rf_we_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic             alu_src_imm_q, alu_src_imm_d;
  logic             ext_sign_q, ext_sign_d;
  logic             rf_dst_rt_q, rf_dst_rt_d;
  logic             ovf_chk_q, ovf_chk_d;
  logic             trap_q, trap_d;
  logic             busy_q, busy_d;
  logic             illegal_q, illegal_d;
  logic             zf_d, of_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [5:0] op, funct;
  logic [4:0] dst;
  logic       dec_halt, dec_ill, dec_imm, dec_sign, dec_rt, dec_ovf;
  logic [3:0] dec_alu_op;
  logic       trap_now;
  logic       unused_inst;

  assign op          = inst[31:26];
  assign funct       = inst[5:0];
  assign unused_inst = ^{inst[25:21], inst[10:6]};

  always_comb begin
    dec_halt   = 1'b0;
    dec_ill    = 1'b0;
    dec_alu_op = 4'd0;
    dec_imm    = 1'b0;
    dec_sign   = 1'b0;
    dec_rt     = 1'b0;
    dec_ovf    = 1'b0;
    if (op == HALT_OP) begin
      dec_halt = 1'b1;
    end else begin
      case (op)
        6'b000000: begin
          case (funct)
            6'b100100: dec_alu_op = 4'd0;
            6'b100101: dec_alu_op = 4'd1;
            6'b100000: begin dec_alu_op = 4'd2; dec_ovf = 1'b1; end
            6'b100110: dec_alu_op = 4'd3;
            6'b100111: dec_alu_op = 4'd4;
            6'b000100: dec_alu_op = 4'd5;
            6'b100010: begin dec_alu_op = 4'd6; dec_ovf = 1'b1; end
            6'b101011: dec_alu_op = 4'd7;
            default:   dec_ill    = 1'b1;
          endcase
        end
        6'b001000: begin
          dec_alu_op = 4'd2; dec_imm = 1'b1; dec_sign = 1'b1; dec_rt = 1'b1; dec_ovf = 1'b1;
        end
        6'b001100: begin dec_alu_op = 4'd0; dec_imm = 1'b1; dec_rt = 1'b1; end
        6'b001101: begin dec_alu_op = 4'd1; dec_imm = 1'b1; dec_rt = 1'b1; end
        6'b001110: begin dec_alu_op = 4'd3; dec_imm = 1'b1; dec_rt = 1'b1; end
        6'b001011: begin dec_alu_op = 4'd7; dec_imm = 1'b1; dec_sign = 1'b1; dec_rt = 1'b1; end
        default:   dec_ill = 1'b1;
      endcase
    end
  end

  // Destination and trap are evaluated in EX from the fields latched at ID exit.
  assign dst      = rf_dst_rt_q ? inst[20:16] : inst[15:11];
  assign trap_now = TRAP_EN & ovf_chk_q & ofa;

  always_comb begin
    state_d       = state_q;
    stop_pend_d   = stop_pend_q;
    alu_op_d      = alu_op_q;
    alu_src_imm_d = alu_src_imm_q;
    ext_sign_d    = ext_sign_q;
    rf_dst_rt_d   = rf_dst_rt_q;
    ovf_chk_d     = ovf_chk_q;
    trap_d        = trap_q;
    illegal_d     = illegal_q;
    zf_d          = zf_q;
    of_d          = of_q;
    cnt_d         = cnt_q;
    rf_we_d       = 1'b0;

    if (stop && (state_q != S_HALT)) begin
      stop_pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        // A stop in IDLE is consumed immediately by refusing the start.
        stop_pend_d = 1'b0;
        if (start && !stop) begin
          state_d = S_IF;
        end
      end
      S_IF: state_d = S_ID;
      S_ID: begin
        alu_op_d      = dec_alu_op;
        alu_src_imm_d = dec_imm;
        ext_sign_d    = dec_sign;
        rf_dst_rt_d   = dec_rt;
        ovf_chk_d     = dec_ovf;
        if (dec_halt) begin
          state_d = S_HALT;
        end else if (dec_ill) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        zf_d    = zfa;
        of_d    = ofa;
        trap_d  = trap_now;
        rf_we_d = (dst != 5'd0) && !trap_now;
        state_d = S_WB;
      end
      S_WB: begin
        trap_d = 1'b0;
        if (trap_q) begin
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (stop_pend_q || stop) begin
            state_d     = S_IDLE;
            stop_pend_d = 1'b0;
          end else begin
            state_d = S_IF;
          end
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    pc_we_d = (state_d == S_IF);
    ir_we_d = (state_d == S_IF);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      state_q       <= S_IDLE;
      stop_pend_q   <= 1'b0;
      pc_we_q       <= 1'b0;
      ir_we_q       <= 1'b0;
      rf_we_q       <= 1'b0;
      alu_op_q      <= 4'd0;
      alu_src_imm_q <= 1'b0;
      ext_sign_q    <= 1'b0;
      rf_dst_rt_q   <= 1'b0;
      ovf_chk_q     <= 1'b0;
      trap_q        <= 1'b0;
      busy_q        <= 1'b0;
      illegal_q     <= 1'b0;
      zf_q          <= 1'b0;
      of_q          <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      stop_pend_q   <= stop_pend_d;
      pc_we_q       <= pc_we_d;
      ir_we_q       <= ir_we_d;
      rf_we_q       <= rf_we_d;
      alu_op_q      <= alu_op_d;
      alu_src_imm_q <= alu_src_imm_d;
      ext_sign_q    <= ext_sign_d;
      rf_dst_rt_q   <= rf_dst_rt_d;
      ovf_chk_q     <= ovf_chk_d;
      trap_q        <= trap_d;
      busy_q        <= busy_d;
      illegal_q     <= illegal_d;
      zf_q          <= zf_d;
      of_q          <= of_d;
      cnt_q         <= cnt_d;
    end
  end

  // Control fields follow the live decode in ID, then the latched copy through WB.
  assign alu_op      = (state_q == S_ID) ? dec_alu_op : alu_op_q;
  assign alu_src_imm = (state_q == S_ID) ? dec_imm    : alu_src_imm_q;
  assign ext_sign    = (state_q == S_ID) ? dec_sign   : ext_sign_q;
  assign rf_dst_rt   = (state_q == S_ID) ? dec_rt     : rf_dst_rt_q;

  assign pc_we    = pc_we_q;
  assign ir_we    = ir_we_q;
  assign rf_we    = rf_we_q;
  assign busy     = busy_q;
  assign illegal  = illegal_q;
  assign state    = state_q;
  assign inst_cnt = cnt_q;

endmodule

// File: tb/tb_ri_multicycle_ctrl.sv
// Directed plus randomized bench for ri_multicycle_ctrl against an instruction-level reference model.
module tb_ri_multicycle_ctrl;
  localparam int CW = 8;
`ifdef RI_OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          clka = 1'b0;
  logic          rsta = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [31:0]   inst = '0;
  logic          zfa = 1'b0;
  logic          ofa = 1'b0;
  logic          pc_we, ir_we, rf_we, alu_src_imm, ext_sign, rf_dst_rt;
  logic          busy, illegal, zf_q, of_q;
  logic [3:0]    alu_op;
  logic [2:0]    state;
  logic [CW-1:0] inst_cnt;

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_cnt = '0;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic [3:0] aop;
    logic       imm;
    logic       sx;
    logic       rt;
    logic       ovf;
  } ent_t;
  ent_t tbl[13];

  ri_multicycle_ctrl #(.HALT_OP(6'b111111), .CNT_W(CW)) dut (
    .clka(clka), .rsta(rsta), .start(start), .stop(stop), .inst(inst),
    .zfa(zfa), .ofa(ofa), .pc_we(pc_we), .ir_we(ir_we), .rf_we(rf_we),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .ext_sign(ext_sign),
    .rf_dst_rt(rf_dst_rt), .busy(busy), .illegal(illegal), .zf_q(zf_q),
    .of_q(of_q), .state(state), .inst_cnt(inst_cnt)
  );

  always #5 clka = ~clka;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // -2 = halt opcode, -1 = unsupported encoding, otherwise table row
  function automatic int lookup(input logic [31:0] i);
    if (i[31:26] == 6'b111111) return -2;
    for (int n = 0; n < 13; n++)
      if (tbl[n].op == i[31:26] && (i[31:26] != 6'd0 || tbl[n].fn == i[5:0])) return n;
    return -1;
  endfunction

  function automatic logic [31:0] make_inst(input int k);
    logic [4:0] rs, rt, rd;
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
    if (tbl[k].op == 6'd0) return {6'd0, rs, rt, rd, 5'd0, tbl[k].fn};
    return {tbl[k].op, rs, rt, 16'($urandom)};
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, {state, busy, pc_we, ir_we, rf_we, alu_op, alu_src_imm, ext_sign,
                        rf_dst_rt, illegal, zf_q, of_q}, 32'd0);
    chk({tag, "_cnt"}, inst_cnt, 32'd0);
  endtask

  task automatic do_reset();
    rsta = 1'b0;
    #1;
    chk_reset("reset");
    exp_cnt = '0;
    @(negedge clka);
    rsta = 1'b1;
  endtask

  task automatic restart();
    do_reset();
    start = 1'b1;
    @(negedge clka);
    chk("restart_if", state, 32'd1);
  endtask

  // Entered at a negedge with the block in IF; returns one negedge after WB (or in HALT).
  task automatic run_inst(input logic [31:0] in, input logic ov, input logic zf, input logic stp);
    int k;
    logic trap;
    logic [4:0] dst;
    logic [6:0] fields;
    k = lookup(in);
    chk("if_state", state, 32'd1);
    chk("if_we", {ir_we, pc_we, rf_we}, 32'b110);
    inst = in;
    @(negedge clka);
    chk("id_state", state, 32'd2);
    chk("id_we", {ir_we, pc_we, rf_we}, 32'd0);
    if (k < 0) begin
      @(negedge clka);
      chk("halt_state", state, 32'd5);
      chk("halt_flags", {illegal, busy, pc_we, ir_we, rf_we}, {27'd0, k == -1, 4'b1000});
      return;
    end
    fields = {tbl[k].aop, tbl[k].imm, tbl[k].sx, tbl[k].rt};
    chk("id_fields", {alu_op, alu_src_imm, ext_sign, rf_dst_rt}, fields);
    @(negedge clka);
    chk("ex_state", state, 32'd3);
    chk("ex_fields", {alu_op, alu_src_imm, ext_sign, rf_dst_rt}, fields);
    chk("ex_we", {ir_we, pc_we, rf_we}, 32'd0);
    zfa = zf; ofa = ov; stop = stp;
    @(negedge clka);
    zfa = 1'b0; ofa = 1'b0; stop = 1'b0;
    trap = TRAP && tbl[k].ovf && ov;
    dst = tbl[k].rt ? in[20:16] : in[15:11];
    chk("wb_state", state, 32'd4);
    chk("wb_rf_we", rf_we, (dst != 5'd0) && !trap);
    chk("wb_pc_ir", {ir_we, pc_we}, 32'd0);
    chk("wb_fields", {alu_op, alu_src_imm, ext_sign, rf_dst_rt}, fields);
    chk("wb_flags", {zf_q, of_q}, {zf, ov});
    if (!trap) exp_cnt++;
    @(negedge clka);
    chk("next_state", state, trap ? 32'd5 : (stp ? 32'd0 : 32'd1));
    chk("busy", busy, !stp || trap);
    chk("cnt", inst_cnt, exp_cnt);
  endtask

  initial begin
    tbl[0]  = '{6'b000000, 6'b100100, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{6'b000000, 6'b100101, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{6'b000000, 6'b100000, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{6'b000000, 6'b100110, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{6'b000000, 6'b100111, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{6'b000000, 6'b000100, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{6'b000000, 6'b100010, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{6'b000000, 6'b101011, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{6'b001000, 6'b000000, 4'd2, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{6'b001100, 6'b000000, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{6'b001101, 6'b000000, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{6'b001110, 6'b000000, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{6'b001011, 6'b000000, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0};

    repeat (2) @(negedge clka);
    chk_reset("por");
    rsta = 1'b1;
    @(negedge clka);
    chk("idle_no_start", state, 32'd0);
    start = 1'b1;
    @(negedge clka);
    chk("start_to_if", state, 32'd1);

    run_inst({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000}, 1'b0, 1'b1, 1'b0);  // add $3,$1,$2
    chk("cnt_after_add", inst_cnt, 32'd1);
    run_inst({6'b001101, 5'd0, 5'd5, 16'h8000}, 1'b0, 1'b0, 1'b0);          // ori $5,$0,0x8000
    run_inst({6'b001000, 5'd4, 5'd0, 16'd7}, 1'b0, 1'b0, 1'b0);              // addi $0,$4,7

    run_inst({6'd0, 5'd1, 5'd2, 5'd7, 5'd0, 6'b100010}, 1'b1, 1'b0, 1'b0);  // sub with overflow
    if (TRAP) begin
      chk("trap_of_q", of_q, 32'd1);
      restart();
    end

    run_inst({6'd0, 5'd1, 5'd2, 5'd9, 5'd0, 6'b100101}, 1'b0, 1'b0, 1'b1);  // stop during EX
    stop = 1'b1;
    @(negedge clka);
    stop = 1'b0;
    chk("start_stop_idle", state, 32'd0);
    @(negedge clka);
    chk("start_after_stop", state, 32'd1);

    for (int n = 0; n < 40; n++) begin
      int k;
      logic stp;
      k = int'($urandom_range(0, 12));
      stp = ($urandom_range(0, 7) == 0);
      run_inst(make_inst(k), TRAP ? 1'b0 : 1'($urandom), 1'($urandom), stp);
      if (stp) begin
        @(negedge clka);
        chk("rnd_restart", state, 32'd1);
      end
    end

    run_inst(32'hFC000000, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clka);
    chk("halt_sticky", {state, busy, illegal}, {27'd0, 3'd5, 1'b1, 1'b0});
    restart();
    run_inst({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b000001}, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clka);
    chk("illegal_sticky", {state, illegal}, {28'd0, 3'd5, 1'b1});

    restart();
    for (int n = 0; n < (1 << CW) - 1; n++)
      run_inst(make_inst(int'($urandom_range(0, 12))), 1'b0, 1'($urandom), 1'b0);
    chk("pre_wrap", inst_cnt, 32'hFF);
    run_inst(make_inst(3), 1'b0, 1'b0, 1'b0);
    chk("wrap", inst_cnt, 32'd0);

    restart();
    inst = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000};
    @(negedge clka);
    @(negedge clka);
    chk("pre_reset_ex", state, 32'd3);
    rsta = 1'b0;
    #1;
    chk_reset("mid_reset");
    @(negedge clka);
    chk_reset("held_reset");
    rsta = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
